mem_stall_ctrl: RTL and testbench

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

---
 rtl/riscv_pkg.sv | 18 +
 rtl/mem_wait_timer.sv | 34 +++
 rtl/mem_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stall_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: memory-stall FSM encoding and default wait budget.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } mem_state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 15;
  localparam int MEM_XLEN_DEFAULT    = 32;

  // Counter width able to hold the value TIMEOUT itself.
  function automatic int timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unanswered wait cycles of an outstanding data-memory request and flags
// when the count has reached TIMEOUT.
module mem_wait_timer
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W     = timer_width(TIMEOUT);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + W'(1);
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_stall_ctrl.sv
// M-stage data-memory handshake: holds the pipeline while a load/store waits for
// mem_ack, and parks in a sticky bus-fault state if the memory never answers.
module mem_stall_ctrl
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int XLEN    = MEM_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            LoadM,
  input  logic            StoreM,
  input  logic            FaultClr,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] ReadDataM,
  output logic            MemStallF,
  output logic            MemStallD,
  output logic            MemStallE,
  output logic            MemStallM,
  output logic            FlushW,
  output logic            BusFault,
  output logic [31:0]     StallCycles
);

  mem_state_e  r_state, w_state_next;
  logic        r_op_we, w_op_we_next;
  logic [31:0] r_stall_cycles;
  logic        w_access, w_stall, w_accept;
  logic        w_timer_clr, w_timer_en, w_expired;

  assign w_access = LoadM | StoreM;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_timer_clr),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_op_we        <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_op_we <= w_op_we_next;
      if (MemStallM && (r_stall_cycles != 32'hFFFF_FFFF))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned and infers a latch.
    w_state_next = r_state;
    w_op_we_next = r_op_we;
    w_timer_clr  = 1'b0;
    w_timer_en   = 1'b0;
    w_stall      = 1'b0;
    w_accept     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    BusFault     = 1'b0;

    case (r_state)
      IDLE: begin
        mem_req = w_access;
        mem_we  = StoreM;
        if (w_access) begin
          if (mem_ack) begin
            w_accept = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_timer_clr  = 1'b1;
            w_op_we_next = StoreM;
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        mem_we  = r_op_we;
        if (mem_ack) begin
          w_accept     = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_stall = 1'b1;
          if (w_expired) w_state_next = FAULT;
          else           w_timer_en   = 1'b1;
        end
      end
      FAULT: begin
        w_stall  = 1'b1;
        BusFault = 1'b1;
        if (FaultClr) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    // IDLE decodes LoadM/StoreM combinationally, so reset must mask it directly.
    if (!rst_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      w_stall  = 1'b0;
      w_accept = 1'b0;
      BusFault = 1'b0;
    end
  end

  assign MemStallF   = w_stall;
  assign MemStallD   = w_stall;
  assign MemStallE   = w_stall;
  assign MemStallM   = w_stall;
  assign FlushW      = w_stall;
  assign ReadDataM   = w_accept ? mem_rdata : '0;
  assign StallCycles = r_stall_cycles;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed scenarios plus randomized
// traffic, all compared against a transaction-level model of the handshake.
module tb_mem_stall_ctrl;

  localparam int TIMEOUT = 15;
  localparam int XLEN    = 32;
  localparam int OBS_W   = 8 + XLEN + 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            LoadM = 1'b0, StoreM = 1'b0, FaultClr = 1'b0, mem_ack = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_req, mem_we, MemStallF, MemStallD, MemStallE, MemStallM;
  logic            FlushW, BusFault;
  logic [XLEN-1:0] ReadDataM;
  logic [31:0]     StallCycles;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .LoadM(LoadM), .StoreM(StoreM), .FaultClr(FaultClr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .MemStallF(MemStallF), .MemStallD(MemStallD),
    .MemStallE(MemStallE), .MemStallM(MemStallM), .FlushW(FlushW),
    .BusFault(BusFault), .StallCycles(StallCycles)
  );

  wire [OBS_W-1:0] obs_vec = {mem_req, mem_we, MemStallF, MemStallD, MemStallE,
                              MemStallM, FlushW, BusFault, ReadDataM, StallCycles};

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level model: an outstanding request, how many cycles it has
  // gone unanswered while pending, a sticky fault flag and the stall total.
  bit              m_pending, m_fault, m_is_store;
  int              m_unanswered;
  longint unsigned m_stall_total;
  bit              e_stall;
  logic [OBS_W-1:0] exp_vec;

  function automatic void model_reset();
    m_pending = 0; m_fault = 0; m_is_store = 0; m_unanswered = 0; m_stall_total = 0;
  endfunction

  function automatic void model_eval();
    logic            req, we, bf;
    logic [XLEN-1:0] rd;
    bit              access;
    access = LoadM | StoreM;
    req = 0; we = 0; bf = 0; rd = '0; e_stall = 0;
    if (m_fault) begin
      e_stall = 1; bf = 1;
    end else if (m_pending) begin
      req = 1; we = m_is_store;
      if (mem_ack) rd = mem_rdata; else e_stall = 1;
    end else begin
      req = access; we = StoreM;
      if (access && mem_ack) rd = mem_rdata;
      e_stall = access && !mem_ack;
    end
    exp_vec = {req, we, {4{e_stall}}, e_stall, bf, rd, m_stall_total[31:0]};
  endfunction

  function automatic void model_step();
    if (e_stall && m_stall_total < 64'hFFFF_FFFF) m_stall_total++;
    if (m_fault) begin
      if (FaultClr) m_fault = 0;
    end else if (m_pending) begin
      if (mem_ack) m_pending = 0;
      else begin
        m_unanswered++;
        if (m_unanswered > TIMEOUT) begin m_pending = 0; m_fault = 1; end
      end
    end else if ((LoadM | StoreM) && !mem_ack) begin
      m_pending = 1; m_is_store = StoreM; m_unanswered = 0;
    end
  endfunction

  task automatic apply(input bit ld, input bit st, input bit clr, input bit ack,
                       input logic [XLEN-1:0] rd);
    LoadM = ld; StoreM = st; FaultClr = clr; mem_ack = ack; mem_rdata = rd;
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    LoadM = 1; StoreM = 1; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    model_reset();
    #2;
    vectors++;
    if (obs_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs_vec, {OBS_W{1'b0}});
    end
    @(posedge clk); #1;
    rst_n = 1; LoadM = 0; StoreM = 0;
    apply(0, 0, 0, 1, 32'h1234_5678);
    vectors++;
    if (obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL idle_ack_ignored: got %h want %h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_zero_wait();
    apply(1, 0, 0, 1, 32'hDEADBEEF);
    vectors++;
    if (obs_vec !== exp_vec || ReadDataM !== 32'hDEADBEEF || MemStallM !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_wait: got %h want %h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_store_wait3();
    logic [31:0] base;
    base = m_stall_total[31:0];
    for (int c = 0; c < 4; c++) begin
      apply(0, 1, 0, c == 3, $urandom);
      vectors++;
      if (obs_vec !== exp_vec || mem_we !== 1'b1 || FlushW !== (c < 3)) begin
        miscompares++;
        $display("FAIL store_wait3 c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    apply(0, 0, 0, 0, '0);
    vectors++;
    if (StallCycles !== base + 32'd3) begin
      miscompares++;
      $display("FAIL store_stall_count: got %0d want %0d", StallCycles, base + 32'd3);
    end
    advance();
  endtask

  task automatic test_timeout_fault();
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      apply(1, 0, 0, 0, $urandom);
      vectors++;
      if (obs_vec !== exp_vec || BusFault !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_wait c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    apply(0, 0, 1, 1, $urandom);
    vectors++;
    if (obs_vec !== exp_vec || BusFault !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_state: got %h want %h", obs_vec, exp_vec);
    end
    advance();
    apply(0, 0, 0, 0, '0);
    vectors++;
    if (obs_vec !== exp_vec || BusFault !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_clear: got %h want %h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_ack_at_timeout();
    for (int c = 0; c < TIMEOUT + 2; c++) begin
      apply(1, 0, 0, c == TIMEOUT + 1, $urandom);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL ack_at_timeout c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
    apply(0, 0, 0, 0, '0);
    vectors++;
    if (obs_vec !== exp_vec || BusFault !== 1'b0 || MemStallM !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_at_timeout_after: got %h want %h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    bit ld_tbl[5]  = '{1, 1, 1, 1, 0};
    bit ack_tbl[5] = '{0, 1, 0, 1, 0};
    for (int c = 0; c < 5; c++) begin
      apply(ld_tbl[c], 0, 0, ack_tbl[c], $urandom);
      vectors++;
      if (obs_vec !== exp_vec || mem_req !== ld_tbl[c]) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_wait();
    for (int c = 0; c < 3; c++) begin
      apply(1, 0, 0, 0, $urandom);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL pre_reset c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      if (c < 2) advance();
    end
    #1 rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (obs_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got %h want %h", obs_vec, {OBS_W{1'b0}});
    end
    @(posedge clk); #1;
    rst_n = 1;
    apply(0, 0, 0, 0, '0);
    vectors++;
    if (obs_vec !== exp_vec || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset: got %h want %h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      int ack_pct;
      ack_pct = (c < 250) ? 45 : 4;
      apply($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 99) < ack_pct, $urandom);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", c, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_store_wait3();
    test_timeout_fault();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
